// File: rtl/ifetch_stage_if.sv
// Instruction-memory read bus: request/address out, acknowledge/data back.
interface ifetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus with a
// bounded wait, and holds the fetched word for the immediate unit downstream.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pc_ld_en,
    input  logic                  i_pc_sel,
    input  logic [31:0]           i_immed,
    ifetch_stage_if.master        imem,
    output logic [31:0]           o_instr,
    output logic [5:0]            o_opcode,
    output logic                  o_instr_valid,
    output logic [31:0]           o_pc,
    output logic                  o_fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_err;

    logic        w_load_instr;
    logic        w_load_pc;
    logic        w_cnt_inc;
    logic        w_cnt_clr;
    logic        w_set_err;
    logic [31:0] w_pc_sum;
    logic [31:0] w_pc_next;

    // Unsigned wrap-around sum; low two bits forced clear to keep word alignment.
    assign w_pc_sum  = r_pc + 32'd4 + (i_pc_sel ? i_immed : 32'd0);
    assign w_pc_next = w_pc_sum & 32'hFFFF_FFFC;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; an ack on the final wait cycle still wins.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_instr = 1'b0;
        w_load_pc    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (imem.ack) begin
                    w_load_instr = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_nxt  = HOLD;
                end else if (r_cnt == LAST_WAIT) begin
                    w_set_err    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            HOLD: begin
                if (i_pc_ld_en) begin
                    w_load_pc   = 1'b1;
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // PC, instruction register, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_load_instr) begin
                r_instr <= imem.rdata;
            end
            if (w_load_pc) begin
                r_pc <= w_pc_next;
            end
            if (w_cnt_clr) begin
                r_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem.req      = (r_state == FETCH);
    assign imem.addr     = r_pc;
    assign o_instr_valid = (r_state == HOLD);
    assign o_instr       = r_instr;
    assign o_opcode      = r_instr[31:26];
    assign o_pc          = r_pc;
    assign o_fetch_err   = r_err;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: main DUT with default timeout, second DUT
// with TIMEOUT=4 and a non-zero reset PC for the retry boundary.
module tb_ifetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ld;
    logic        sel;
    logic [31:0] immed;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        valid;
    logic [31:0] pc;
    logic        err;

    logic        reset2;
    logic [31:0] instr2;
    logic [5:0]  opcode2;
    logic        valid2;
    logic [31:0] pc2;
    logic        err2;

    int n_checks = 0;
    int n_errors = 0;

    ifetch_stage_if bus();
    ifetch_stage_if bus2();

    ifetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .i_pc_ld_en    (ld),
        .i_pc_sel      (sel),
        .i_immed       (immed),
        .imem          (bus.master),
        .o_instr       (instr),
        .o_opcode      (opcode),
        .o_instr_valid (valid),
        .o_pc          (pc),
        .o_fetch_err   (err)
    );

    ifetch_stage #(.RESET_PC(32'h0000_0100), .TIMEOUT(4)) dut2 (
        .clk           (clk),
        .reset         (reset2),
        .i_pc_ld_en    (1'b0),
        .i_pc_sel      (1'b0),
        .i_immed       (32'd0),
        .imem          (bus2.master),
        .o_instr       (instr2),
        .o_opcode      (opcode2),
        .o_instr_valid (valid2),
        .o_pc          (pc2),
        .o_fetch_err   (err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ld = 1'b0; sel = 1'b0; immed = 32'd0;
        bus.ack = 1'b1; bus.rdata = 32'h5A5A_5A5A;
        reset2 = 1'b1; bus2.ack = 1'b0; bus2.rdata = 32'd0;

        // Reset held three cycles with ack high.
        repeat (3) step();
        chk("rst_pc",     pc,                32'h0);
        chk("rst_instr",  instr,             32'h0);
        chk("rst_opcode", {26'd0, opcode},   32'h0);
        chk("rst_valid",  {31'd0, valid},    32'h0);
        chk("rst_req",    {31'd0, bus.req},  32'h0);
        chk("rst_err",    {31'd0, err},      32'h0);

        reset = 1'b0; bus.ack = 1'b0;
        chk("c0_req", {31'd0, bus.req}, 32'h0);
        step();
        chk("c1_req",  {31'd0, bus.req}, 32'h1);
        chk("c1_addr", bus.addr,         32'h0);

        // Zero-wait fetch.
        bus.ack = 1'b1; bus.rdata = 32'hE0A1_0005;
        step();
        chk("zw_instr",  instr,              32'hE0A1_0005);
        chk("zw_opcode", {26'd0, opcode},    32'h0000_0038);
        chk("zw_valid",  {31'd0, valid},     32'h1);
        chk("zw_req",    {31'd0, bus.req},   32'h0);

        // Ack in HOLD is ignored.
        bus.rdata = 32'h0BAD_0BAD;
        step();
        chk("hold_instr", instr,          32'hE0A1_0005);
        chk("hold_valid", {31'd0, valid}, 32'h1);

        // Branch 0 -> 0x10.
        bus.ack = 1'b0; ld = 1'b1; sel = 1'b1; immed = 32'h0000_000C;
        step();
        chk("br0_pc",    pc,               32'h0000_0010);
        chk("br0_addr",  bus.addr,         32'h0000_0010);
        chk("br0_req",   {31'd0, bus.req}, 32'h1);
        chk("br0_valid", {31'd0, valid},   32'h0);

        // pc_ld_en during FETCH is ignored.
        sel = 1'b0; immed = 32'hFFFF_FF00; bus.ack = 1'b1; bus.rdata = 32'h1111_1111;
        step();
        chk("fetch_ld_pc", pc,             32'h0000_0010);
        chk("f2_instr",    instr,          32'h1111_1111);
        chk("f2_valid",    {31'd0, valid}, 32'h1);

        // Sequential 0x10 -> 0x14; immed ignored with pc_sel=0.
        bus.ack = 1'b0;
        step();
        chk("seq_pc",  pc,               32'h0000_0014);
        chk("seq_req", {31'd0, bus.req}, 32'h1);

        ld = 1'b0; bus.ack = 1'b1; bus.rdata = 32'h2222_2222;
        step();
        bus.ack = 1'b0;
        step();
        ld = 1'b1; sel = 1'b1; immed = 32'hFFFF_FFF8;
        step();
        chk("brneg_pc", pc, 32'h0000_0010);
        ld = 1'b0; sel = 1'b0;

        // Wait states: ack on the fifth FETCH cycle, valid five cycles after req.
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("wait_valid", {31'd0, valid},   32'h0);
            chk("wait_req",   {31'd0, bus.req}, 32'h1);
        end
        bus.ack = 1'b1; bus.rdata = 32'h3333_3333;
        step();
        chk("wait_valid_rise", {31'd0, valid}, 32'h1);
        chk("wait_instr",      instr,          32'h3333_3333);
        chk("wait_err",        {31'd0, err},   32'h0);

        // Branch whose raw sum is 0xFFFF_FFFF: low bits forced clear.
        bus.ack = 1'b0;
        step();
        ld = 1'b1; sel = 1'b1; immed = 32'hFFFF_FFEB;
        step();
        chk("align_pc", pc, 32'hFFFF_FFFC);
        ld = 1'b0; sel = 1'b0; bus.ack = 1'b1; bus.rdata = 32'h4444_4444;
        step();
        bus.ack = 1'b0; ld = 1'b1;
        step();
        chk("wrap_pc",   pc,               32'h0);
        chk("wrap_addr", bus.addr,         32'h0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
        chk("pre_rst_pc", pc, 32'h0000_0004);
        ld = 1'b0;

        // Reset mid-fetch with coincident ack.
        reset = 1'b1; bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        step();
        chk("mrst_instr", instr,            32'h0);
        chk("mrst_valid", {31'd0, valid},   32'h0);
        chk("mrst_pc",    pc,               32'h0);
        chk("mrst_req",   {31'd0, bus.req}, 32'h0);
        reset = 1'b0; bus.ack = 1'b0;

        // Timeout on the TIMEOUT=4 instance.
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        chk("to_c0_req", {31'd0, bus2.req}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("to_req",  {31'd0, bus2.req}, 32'h1);
            chk("to_addr", bus2.addr,         32'h0000_0100);
            chk("to_err",  {31'd0, err2},     32'h0);
        end
        step();
        chk("to_idle_req", {31'd0, bus2.req}, 32'h0);
        chk("to_err_set",  {31'd0, err2},     32'h1);
        step();
        chk("retry_req",  {31'd0, bus2.req}, 32'h1);
        chk("retry_addr", bus2.addr,         32'h0000_0100);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("retry_wait_req", {31'd0, bus2.req}, 32'h1);
            chk("retry_wait_err", {31'd0, err2},     32'h1);
        end
        bus2.ack = 1'b1; bus2.rdata = 32'h5555_5555;
        step();
        chk("edge_ack_valid", {31'd0, valid2},   32'h1);
        chk("edge_ack_instr", instr2,            32'h5555_5555);
        chk("edge_ack_req",   {31'd0, bus2.req}, 32'h0);
        chk("edge_ack_err",   {31'd0, err2},     32'h1);
        bus2.ack = 1'b0;
        step();
        chk("no_retry_req", {31'd0, bus2.req}, 32'h0);
        chk("no_retry_err", {31'd0, err2},     32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
